// File: rtl/router_fsm_if.sv
// Handshake/status bundle between the router datapath blocks and the router controller FSM.
interface router_fsm_if;
   logic       pkt_valid;
   logic       parity_done;
   logic       fifo_full;
   logic       low_pkt_valid;
   logic       soft_reset0;
   logic       soft_reset1;
   logic       soft_reset2;
   logic       fifo_empty0;
   logic       fifo_empty1;
   logic       fifo_empty2;
   logic [1:0] data_in;

   logic       busy;
   logic       detect_addr;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       write_enb_reg;
   logic       rst_int_reg;
   logic       lfd_state;

   modport master (
      output pkt_valid, parity_done, fifo_full, low_pkt_valid,
             soft_reset0, soft_reset1, soft_reset2,
             fifo_empty0, fifo_empty1, fifo_empty2, data_in,
      input  busy, detect_addr, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, lfd_state
   );

   modport slave (
      input  pkt_valid, parity_done, fifo_full, low_pkt_valid,
             soft_reset0, soft_reset1, soft_reset2,
             fifo_empty0, fifo_empty1, fifo_empty2, data_in,
      output busy, detect_addr, ld_state, laf_state, full_state,
             write_enb_reg, rst_int_reg, lfd_state
   );
endinterface

// File: rtl/router_fsm.sv
// Moore controller of a 1-to-3 packet router: header decode, payload/parity load, full stalls.
// Optional debug outputs (state_dbg, addr_dbg) are enabled by ROUTER_FSM_STATE_OUT_EN.
module router_fsm (
   input  logic        clock,
   input  logic        resetn,
   router_fsm_if.slave bus
`ifdef ROUTER_FSM_STATE_OUT_EN
   ,
   output logic [2:0]  state_dbg,
   output logic [1:0]  addr_dbg
`endif
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [1:0] addr;
   logic [3:0] empty_vec;
   logic [3:0] srst_vec;
   logic       hdr_ok;

   // Address 3 is not a destination, so bit 3 of each vector stays inactive.
   assign empty_vec = {1'b0, bus.fifo_empty2, bus.fifo_empty1, bus.fifo_empty0};
   assign srst_vec  = {1'b0, bus.soft_reset2, bus.soft_reset1, bus.soft_reset0};
   assign hdr_ok    = bus.pkt_valid && (bus.data_in != 2'd3);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= DECODE_ADDRESS;
         addr  <= 2'd0;
      end else begin
         state <= state_next;
         if (state == DECODE_ADDRESS && hdr_ok)
            addr <= bus.data_in;
      end
   end

   always_comb begin
      state_next = state;
      if (state != DECODE_ADDRESS && srst_vec[addr]) begin
         state_next = DECODE_ADDRESS;
      end else begin
         unique case (state)
            DECODE_ADDRESS:
               if (hdr_ok)
                  state_next = empty_vec[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
               state_next = LOAD_DATA;
            LOAD_DATA:
               if (bus.fifo_full)       state_next = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_next = LOAD_PARITY;
            FIFO_FULL_STATE:
               if (!bus.fifo_full)      state_next = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
               if (bus.parity_done)        state_next = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_next = LOAD_PARITY;
               else                        state_next = LOAD_DATA;
            LOAD_PARITY:
               state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               state_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
               if (empty_vec[addr])     state_next = LOAD_FIRST_DATA;
            default:
               state_next = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      bus.detect_addr   = (state == DECODE_ADDRESS);
      bus.lfd_state     = (state == LOAD_FIRST_DATA);
      bus.ld_state      = (state == LOAD_DATA);
      bus.full_state    = (state == FIFO_FULL_STATE);
      bus.laf_state     = (state == LOAD_AFTER_FULL);
      bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
      bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                          (state == LOAD_PARITY);
      // The router accepts bytes only while decoding a header or streaming payload.
      bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
   end

`ifdef ROUTER_FSM_STATE_OUT_EN
   assign state_dbg = state;
   assign addr_dbg  = addr;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed and randomized bench for router_fsm against a phase-table reference model.
module tb_router_fsm;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   router_fsm_if bus();

`ifdef ROUTER_FSM_STATE_OUT_EN
   logic [2:0] state_dbg;
   logic [1:0] addr_dbg;
   router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus),
                   .state_dbg(state_dbg), .addr_dbg(addr_dbg));
`else
   router_fsm dut (.clock(clock), .resetn(resetn), .bus(bus));
`endif

   localparam int P_DA = 0, P_LFD = 1, P_LD = 2, P_FFS = 3,
                  P_LAF = 4, P_LP = 5, P_CPE = 6, P_WTE = 7;

   int         m_ph;
   logic [1:0] m_addr;
   int         checks   = 0;
   int         failures = 0;

   // Output vector order: {busy, detect_addr, ld, laf, full, write_enb, rst_int, lfd}
   function automatic logic [7:0] outs_of(int ph);
      logic [7:0] v;
      v = 8'h00;
      case (ph)
         P_DA:  v = 8'b0100_0000;
         P_LFD: v = 8'b1000_0001;
         P_LD:  v = 8'b0010_0100;
         P_FFS: v = 8'b1000_1000;
         P_LAF: v = 8'b1001_0100;
         P_LP:  v = 8'b1000_0100;
         P_CPE: v = 8'b1000_0010;
         P_WTE: v = 8'b1000_0000;
         default: v = 8'hxx;
      endcase
      return v;
   endfunction

   function automatic logic [7:0] dut_outs();
      return {bus.busy, bus.detect_addr, bus.ld_state, bus.laf_state,
              bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.lfd_state};
   endfunction

   function automatic bit empty_of(logic [1:0] a);
      case (a)
         2'd0: return bus.fifo_empty0;
         2'd1: return bus.fifo_empty1;
         2'd2: return bus.fifo_empty2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit srst_of(logic [1:0] a);
      case (a)
         2'd0: return bus.soft_reset0;
         2'd1: return bus.soft_reset1;
         2'd2: return bus.soft_reset2;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int model_next(int ph, logic [1:0] a);
      if (ph != P_DA && srst_of(a)) return P_DA;
      case (ph)
         P_DA:  if (bus.pkt_valid && bus.data_in != 2'd3)
                   return empty_of(bus.data_in) ? P_LFD : P_WTE;
                else return P_DA;
         P_LFD: return P_LD;
         P_LD:  return bus.fifo_full ? P_FFS : (!bus.pkt_valid ? P_LP : P_LD);
         P_FFS: return bus.fifo_full ? P_FFS : P_LAF;
         P_LAF: return bus.parity_done ? P_DA : (bus.low_pkt_valid ? P_LP : P_LD);
         P_LP:  return P_CPE;
         P_CPE: return bus.fifo_full ? P_FFS : P_DA;
         P_WTE: return empty_of(a) ? P_LFD : P_WTE;
         default: return P_DA;
      endcase
   endfunction

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_model(string tag);
      check(tag, dut_outs(), outs_of(m_ph));
`ifdef ROUTER_FSM_STATE_OUT_EN
      check({tag, "_state"}, {5'd0, state_dbg}, 8'(m_ph));
      check({tag, "_addr"},  {6'd0, addr_dbg},  {6'd0, m_addr});
`endif
   endtask

   // One clock: model advances from the inputs present at the edge, DUT sampled 1ns later.
   task automatic cycle(string tag);
      int nx;
      nx = model_next(m_ph, m_addr);
      if (m_ph == P_DA && bus.pkt_valid && bus.data_in != 2'd3) m_addr = bus.data_in;
      @(posedge clock);
      m_ph = nx;
      #1;
      check_model(tag);
   endtask

   task automatic step(string tag, int ph);
      cycle(tag);
      check({tag, "_fixed"}, dut_outs(), outs_of(ph));
   endtask

   task automatic async_reset(string tag);
      resetn = 1'b0;
      #1;
      m_ph   = P_DA;
      m_addr = 2'd0;
      check(tag, dut_outs(), outs_of(P_DA));
      resetn = 1'b1;
   endtask

   task automatic set_in(bit pv, logic [1:0] din, bit ff, bit lpv, bit pd);
      bus.pkt_valid     = pv;
      bus.data_in       = din;
      bus.fifo_full     = ff;
      bus.low_pkt_valid = lpv;
      bus.parity_done   = pd;
   endtask

   initial begin
      resetn = 1'b0;
      set_in(0, 2'd0, 0, 0, 0);
      bus.soft_reset0 = 0; bus.soft_reset1 = 0; bus.soft_reset2 = 0;
      bus.fifo_empty0 = 1; bus.fifo_empty1 = 1; bus.fifo_empty2 = 1;
      m_ph = P_DA; m_addr = 2'd0;
      repeat (2) @(negedge clock);
      check("reset_outs", dut_outs(), outs_of(P_DA));
      resetn = 1'b1;
      @(negedge clock);
      step("idle0", P_DA);
      step("idle1", P_DA);

      // Normal packet to port 0
      set_in(1, 2'd0, 0, 0, 0);
      step("p0_lfd", P_LFD);
      step("p0_ld", P_LD);
      set_in(0, 2'd0, 0, 0, 0);
      step("p0_lp", P_LP);
      step("p0_cpe", P_CPE);
      step("p0_da", P_DA);

      // Full stall on port 1, parity pending after stall
      set_in(1, 2'd1, 0, 0, 0);
      step("p1_lfd", P_LFD);
      step("p1_ld", P_LD);
      set_in(1, 2'd1, 1, 0, 0);
      step("p1_ffs", P_FFS);
      set_in(0, 2'd1, 0, 1, 0);
      step("p1_laf", P_LAF);
      step("p1_lp", P_LP);
      set_in(0, 2'd1, 0, 0, 0);
      step("p1_cpe", P_CPE);
      step("p1_da", P_DA);

      // LAF resumes payload
      set_in(1, 2'd0, 0, 0, 0);
      step("r_lfd", P_LFD);
      step("r_ld", P_LD);
      set_in(1, 2'd0, 1, 0, 0);
      step("r_ffs", P_FFS);
      set_in(1, 2'd0, 0, 0, 0);
      step("r_laf", P_LAF);
      step("r_ld2", P_LD);
      set_in(0, 2'd0, 0, 0, 0);
      step("r_lp", P_LP);
      step("r_cpe", P_CPE);
      step("r_da", P_DA);

      // CPE with FIFO full, port 2; full and !pkt_valid together in LD
      set_in(1, 2'd2, 0, 0, 0);
      step("c_lfd", P_LFD);
      step("c_ld", P_LD);
      set_in(0, 2'd2, 1, 0, 0);
      step("c_ffs_pri", P_FFS);
      set_in(0, 2'd2, 0, 1, 0);
      step("c_laf", P_LAF);
      step("c_lp", P_LP);
      set_in(0, 2'd2, 1, 0, 0);
      step("c_cpe", P_CPE);
      step("c_ffs", P_FFS);
      set_in(0, 2'd2, 0, 0, 0);
      step("c_laf2", P_LAF);
      set_in(0, 2'd2, 0, 0, 1);
      step("c_da", P_DA);

      // Wait for busy FIFO 2, then release
      bus.parity_done = 0;
      bus.fifo_empty2 = 0;
      set_in(1, 2'd2, 0, 0, 0);
      step("w_wte", P_WTE);
      step("w_wte2", P_WTE);
      bus.fifo_empty2 = 1;
      set_in(1, 2'd0, 0, 0, 0);
      step("w_lfd", P_LFD);
      set_in(0, 2'd0, 0, 0, 0);
      step("w_ld", P_LD);
      step("w_lp", P_LP);
      step("w_cpe", P_CPE);
      step("w_da", P_DA);

      // Soft reset from WTE, and a soft reset for a different port is ignored
      bus.fifo_empty2 = 0;
      set_in(1, 2'd2, 0, 0, 0);
      step("s_wte", P_WTE);
      set_in(0, 2'd2, 0, 0, 0);
      bus.soft_reset0 = 1;
      step("s_other", P_WTE);
      bus.soft_reset0 = 0;
      bus.soft_reset2 = 1;
      step("s_da", P_DA);
      bus.soft_reset2 = 0;
      bus.fifo_empty2 = 1;

      // Soft reset has priority over full in LD
      set_in(1, 2'd1, 0, 0, 0);
      step("s1_lfd", P_LFD);
      step("s1_ld", P_LD);
      set_in(1, 2'd1, 1, 0, 0);
      bus.soft_reset1 = 1;
      step("s1_da", P_DA);
      bus.soft_reset1 = 0;

      // Address 3 never leaves DA
      set_in(1, 2'd3, 0, 0, 0);
      step("a3_da", P_DA);
      step("a3_da2", P_DA);

      // Asynchronous reset mid-packet
      set_in(1, 2'd0, 0, 0, 0);
      step("m_lfd", P_LFD);
      step("m_ld", P_LD);
      async_reset("m_async");
      set_in(0, 2'd0, 0, 0, 0);
      step("m_da", P_DA);
      step("m_da2", P_DA);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         bus.pkt_valid     = ($urandom_range(0, 9) < 7);
         bus.data_in       = 2'($urandom_range(0, 3));
         bus.fifo_full     = ($urandom_range(0, 3) == 0);
         bus.low_pkt_valid = $urandom_range(0, 1) != 0;
         bus.parity_done   = ($urandom_range(0, 3) == 0);
         bus.fifo_empty0   = ($urandom_range(0, 3) != 0);
         bus.fifo_empty1   = ($urandom_range(0, 3) != 0);
         bus.fifo_empty2   = ($urandom_range(0, 3) != 0);
         bus.soft_reset0   = ($urandom_range(0, 19) == 0);
         bus.soft_reset1   = ($urandom_range(0, 19) == 0);
         bus.soft_reset2   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0) async_reset($sformatf("rnd_rst%0d", i));
         cycle($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
